act_window_gen: RTL and testbench

ACT_WINDOW_GEN -- requirements
Module: act_window_gen

---
 rtl/act_window_gen.sv | 109 ++++++++++
 tb/tb_act_window_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/act_window_gen.sv
// Sliding KxK activation window generator: turns a raster pixel stream into
// one registered window per valid output position, using K-1 line buffers.
module act_window_gen #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [DATA_W-1:0]        pix_data,
  output logic                     pix_ready,
  output logic                     win_valid,
  output logic [K*K*DATA_W-1:0]    win_act,
  output logic                     win_last,
  output logic                     frame_done,
  output logic                     sof_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                          state, state_nxt;
  logic [RW-1:0]                   row, cur_row;
  logic [CW-1:0]                   col, cur_col;
  logic                            acc, proc, is_last, fire;
  logic [DATA_W-1:0]               lb [K-1][IMG_W];
  logic [K-1:0][K-1:0][DATA_W-1:0] win, win_nxt;
  logic [K-1:0][DATA_W-1:0]        col_vec;

  assign pix_ready  = (state != DONE);
  assign frame_done = (state == DONE);
  assign acc        = pix_valid && pix_ready;
  // An sof pixel always (re)starts the frame at (0,0); anything else only counts mid-frame.
  assign proc       = acc && ((state == ACTIVE) || pix_sof);
  assign cur_row    = pix_sof ? '0 : row;
  assign cur_col    = pix_sof ? '0 : col;
  assign is_last    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign fire       = proc && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACTIVE: if (proc) state_nxt = is_last ? DONE : ACTIVE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Column entering the window: r=0 is the oldest row, r=K-1 the live pixel.
  always_comb begin
    col_vec[K-1] = pix_data;
    for (int r = 0; r < K-1; r++) col_vec[r] = lb[K-2-r][cur_col];
    win_nxt = win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K-1] = col_vec[r];
    end
  end

  // Line buffers and the shifting window need no reset: stale data is
  // overwritten before any window that depends on it can fire.
  always_ff @(posedge clk) begin
    if (proc) begin
      lb[0][cur_col] <= pix_data;
      for (int j = 1; j < K-1; j++) lb[j][cur_col] <= lb[j-1][cur_col];
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      sof_err   <= 1'b0;
      win_act   <= '0;
    end else begin
      win_valid <= fire;
      win_last  <= fire && is_last;
      sof_err   <= acc && pix_sof && (state == ACTIVE);
      if (fire) win_act <= win_nxt;
      if (proc) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= is_last ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_window_gen.sv
// Directed bench for act_window_gen: ramp frames with gaps, idle discard,
// mid-frame sof, mid-frame reset and back-to-back frames.
module tb_act_window_gen;
  localparam int W = 32, H = 32, K = 5, DW = 16, NWIN = 784, WPR = 28;

  logic clk = 1'b0, rstn = 1'b0, pix_valid = 1'b0, pix_sof = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic pix_ready, win_valid, win_last, frame_done, sof_err;
  logic [K*K*DW-1:0] win_act;

  int tests = 0, fails = 0, cyc = 0;
  logic [K*K*DW-1:0] wq[$];
  bit lq[$];
  int wcyc[$];
  int done_cnt = 0, done_cyc = 0, serr_cnt = 0, ready_low = 0, unstable = 0;
  bit chk_stable = 1'b0;
  logic [K*K*DW-1:0] last_act = '0;
  int acc_cyc[1024];
  int last_acc = 0;

  act_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .win_valid(win_valid),
    .win_act(win_act), .win_last(win_last), .frame_done(frame_done),
    .sof_err(sof_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      wq.push_back(win_act);
      lq.push_back(win_last);
      wcyc.push_back(cyc);
      last_act = win_act;
    end else if (chk_stable && win_act !== last_act) unstable++;
    if (frame_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (sof_err === 1'b1) serr_cnt++;
    if (pix_ready === 1'b0) ready_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Window n of a ramp frame sits at pixel (n/28+4, n%28+4); tap r*K+c holds pixel (R-4+r, C-4+c).
  function automatic logic [K*K*DW-1:0] exp_win(input int n);
    logic [K*K*DW-1:0] w;
    int rr, cc;
    rr = n / WPR + K - 1;
    cc = n % WPR + K - 1;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = DW'((rr-K+1+r)*W + (cc-K+1+c));
    return w;
  endfunction

  task automatic clear_mon();
    wq.delete(); lq.delete(); wcyc.delete();
    done_cnt = 0; serr_cnt = 0; ready_low = 0; unstable = 0;
  endtask

  task automatic flush();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [DW-1:0] d, input bit sof);
    int n;
    n = 0;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    while (pix_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL push_timeout: pix_ready=%b, required 1", pix_ready);
    end
    @(posedge clk); #1;
    last_acc = cyc;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_ramp(input int first, input int count, input bit gaps);
    for (int i = first; i < first + count; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      push(DW'(i), i == 0);
      acc_cyc[i] = last_acc;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (win_valid !== 1'b0) begin fails++; $display("FAIL rst_win_valid: got %b, want 0", win_valid); end
    tests++; if (win_last !== 1'b0) begin fails++; $display("FAIL rst_win_last: got %b, want 0", win_last); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done: got %b, want 0", frame_done); end
    tests++; if (sof_err !== 1'b0) begin fails++; $display("FAIL rst_sof_err: got %b, want 0", sof_err); end
    tests++; if (win_act !== '0) begin fails++; $display("FAIL rst_win_act: got %h, want 0", win_act); end
    rstn = 1'b1;
    @(posedge clk); #1;
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL rst_pix_ready: got %b, want 1", pix_ready); end
  endtask

  task automatic test_ramp();
    logic [K*K*DW-1:0] f, l;
    int bad, nl;
    clear_mon();
    send_ramp(0, 1024, 1'b0);
    flush();
    bad = 0; nl = 0;
    for (int n = 0; n < NWIN; n++) if (n >= wq.size() || wq[n] !== exp_win(n)) bad++;
    foreach (lq[i]) if (lq[i]) nl++;
    f = (wq.size() > 0) ? wq[0] : 'x;
    l = (wq.size() > 0) ? wq[wq.size()-1] : 'x;
    tests++; if (wq.size() !== NWIN) begin fails++; $display("FAIL ramp_count: got %0d, want %0d", wq.size(), NWIN); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL ramp_windows: %0d bad windows, want 0", bad); end
    tests++; if (f[0*DW +: DW] !== 16'd0) begin fails++; $display("FAIL ramp_first_tap0: got %0d, want 0", f[0*DW +: DW]); end
    tests++; if (f[5*DW +: DW] !== 16'd32) begin fails++; $display("FAIL ramp_first_tap5: got %0d, want 32", f[5*DW +: DW]); end
    tests++; if (f[24*DW +: DW] !== 16'd132) begin fails++; $display("FAIL ramp_first_tap24: got %0d, want 132", f[24*DW +: DW]); end
    tests++; if (l[24*DW +: DW] !== 16'd1023) begin fails++; $display("FAIL ramp_last_tap24: got %0d, want 1023", l[24*DW +: DW]); end
    tests++; if (l[0*DW +: DW] !== 16'd891) begin fails++; $display("FAIL ramp_last_tap0: got %0d, want 891", l[0*DW +: DW]); end
    tests++; if (wcyc.size() == 0 || wcyc[0] !== acc_cyc[132]) begin fails++; $display("FAIL ramp_first_latency: first window cycle %0d, want %0d", (wcyc.size() > 0) ? wcyc[0] : -1, acc_cyc[132]); end
    tests++; if (lq.size() == 0 || lq[lq.size()-1] !== 1'b1 || nl !== 1) begin fails++; $display("FAIL ramp_win_last: %0d flags set, want 1 on final window", nl); end
    tests++; if (done_cnt !== 1 || done_cyc !== acc_cyc[1023]) begin fails++; $display("FAIL ramp_frame_done: %0d pulses at cycle %0d, want 1 at %0d", done_cnt, done_cyc, acc_cyc[1023]); end
    tests++; if (serr_cnt !== 0) begin fails++; $display("FAIL ramp_sof_err: got %0d pulses, want 0", serr_cnt); end
    tests++; if (ready_low !== 1) begin fails++; $display("FAIL ramp_ready_low: got %0d cycles, want 1", ready_low); end
  endtask

  task automatic test_gaps();
    int bad;
    clear_mon();
    chk_stable = 1'b1;
    send_ramp(0, 1024, 1'b1);
    flush();
    chk_stable = 1'b0;
    bad = 0;
    for (int n = 0; n < NWIN; n++) if (n >= wq.size() || wq[n] !== exp_win(n)) bad++;
    tests++; if (wq.size() !== NWIN) begin fails++; $display("FAIL gaps_count: got %0d, want %0d", wq.size(), NWIN); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL gaps_windows: %0d bad windows, want 0", bad); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL gaps_hold: win_act changed %0d times while idle, want 0", unstable); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL gaps_frame_done: got %0d, want 1", done_cnt); end
  endtask

  task automatic test_idle_discard();
    int bad;
    clear_mon();
    repeat (3) push(16'hAAAA, 1'b0);
    flush();
    tests++; if (wq.size() !== 0 || done_cnt !== 0 || pix_ready !== 1'b1) begin fails++; $display("FAIL idle_ignore: windows %0d done %0d ready %b, want 0 0 1", wq.size(), done_cnt, pix_ready); end
    send_ramp(0, 1024, 1'b0);
    flush();
    bad = 0;
    for (int n = 0; n < NWIN; n++) if (n >= wq.size() || wq[n] !== exp_win(n)) bad++;
    tests++; if (wq.size() !== NWIN || bad !== 0) begin fails++; $display("FAIL idle_frame: count %0d bad %0d, want %0d 0", wq.size(), bad, NWIN); end
    tests++; if (lq.size() == 0 || lq[lq.size()-1] !== 1'b1 || done_cnt !== 1) begin fails++; $display("FAIL idle_end: done %0d, want 1 with win_last on final window", done_cnt); end
  endtask

  task automatic test_sof_restart();
    int bad, nl;
    clear_mon();
    send_ramp(0, 200, 1'b0);
    send_ramp(0, 1024, 1'b0);
    flush();
    bad = 0; nl = 0;
    // 60 windows come from the abandoned partial frame before the restart.
    for (int n = 0; n < 60; n++) if (n >= wq.size() || wq[n] !== exp_win(n)) bad++;
    for (int n = 0; n < NWIN; n++) if (n + 60 >= wq.size() || wq[n+60] !== exp_win(n)) bad++;
    foreach (lq[i]) if (lq[i]) nl++;
    tests++; if (serr_cnt !== 1) begin fails++; $display("FAIL sof_err_count: got %0d, want 1", serr_cnt); end
    tests++; if (wq.size() !== 60 + NWIN) begin fails++; $display("FAIL sof_count: got %0d, want %0d", wq.size(), 60 + NWIN); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL sof_windows: %0d bad windows, want 0", bad); end
    tests++; if (done_cnt !== 1 || nl !== 1) begin fails++; $display("FAIL sof_end: done %0d last %0d, want 1 1", done_cnt, nl); end
  endtask

  task automatic test_mid_reset();
    int bad;
    clear_mon();
    send_ramp(0, 500, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    tests++; if (wq.size() !== 324) begin fails++; $display("FAIL mrst_pre_count: got %0d, want 324", wq.size()); end
    tests++; if (win_valid !== 1'b0 || win_last !== 1'b0 || frame_done !== 1'b0 || sof_err !== 1'b0 || win_act !== '0) begin fails++; $display("FAIL mrst_outputs: valid %b last %b done %b err %b act %h, want all 0", win_valid, win_last, frame_done, sof_err, win_act); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready: got %b, want 1", pix_ready); end
    clear_mon();
    repeat (3) push(16'd5, 1'b0);
    flush();
    tests++; if (wq.size() !== 0) begin fails++; $display("FAIL mrst_no_window: got %0d, want 0", wq.size()); end
    send_ramp(0, 1024, 1'b0);
    flush();
    bad = 0;
    for (int n = 0; n < NWIN; n++) if (n >= wq.size() || wq[n] !== exp_win(n)) bad++;
    tests++; if (wq.size() !== NWIN || bad !== 0) begin fails++; $display("FAIL mrst_frame: count %0d bad %0d, want %0d 0", wq.size(), bad, NWIN); end
    tests++; if (lq.size() == 0 || lq[lq.size()-1] !== 1'b1 || done_cnt !== 1) begin fails++; $display("FAIL mrst_end: done %0d, want 1 with win_last on final window", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad, nl;
    clear_mon();
    send_ramp(0, 1024, 1'b0);
    send_ramp(0, 1, 1'b0);
    tests++; if (ready_low !== 1) begin fails++; $display("FAIL b2b_gap: pix_ready low %0d cycles, want 1", ready_low); end
    send_ramp(1, 1023, 1'b0);
    flush();
    bad = 0; nl = 0;
    for (int n = 0; n < 2*NWIN; n++) if (n >= wq.size() || wq[n] !== exp_win(n % NWIN)) bad++;
    foreach (lq[i]) if (lq[i]) nl++;
    tests++; if (wq.size() !== 2*NWIN) begin fails++; $display("FAIL b2b_count: got %0d, want %0d", wq.size(), 2*NWIN); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_windows: %0d bad windows, want 0", bad); end
    tests++; if (done_cnt !== 2 || nl !== 2) begin fails++; $display("FAIL b2b_end: done %0d last %0d, want 2 2", done_cnt, nl); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_idle_discard();
    test_sof_restart();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
